magic_nmi_hub: RTL and testbench

//  Parametrised next-generation magic/NMI controller.
//  - Arbitrates N_SRC NMI trigger sources and maps the magic ROM.
//  - Verifies a SIG_LEN-opcode signature before committing to the magic ROM.
//  - Exposes a CFG_REGS x 8-bit config bank on port #xx<CFG_PORT>.
//  - Adds NMI acknowledge timeout and a readable trigger-ID status.
//  - Sits between the CPU bus and the memory/port decoders, next to the ROM mapper.

---
 rtl/magic_nmi_hub_pkg.sv | 31 +++
 rtl/magic_nmi_hub_bus.sv | 14 +
 rtl/magic_nmi_hub_cfg_bank.sv | 61 ++++++
 rtl/magic_nmi_hub.sv | 179 +++++++++++++++++
 tb/tb_magic_nmi_hub.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/magic_nmi_hub_pkg.sv
// Shared types and constants for the magic/NMI hub.
// State encoding, status bit layout and the entry-vector helper.
package magic_nmi_hub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CHECK,
        ST_MAPPED,
        ST_UNMAP,
        ST_CALL
    } magic_state_t;

    localparam int STATUS_MAP   = 0;
    localparam int STATUS_MODE  = 1;
    localparam int STATUS_ONE   = 2;
    localparam int STATUS_NOSIG = 3;
    localparam int STATUS_TMO   = 4;
    localparam int STATUS_ID    = 5;

    localparam int CFG_IDX_STATUS = 0;

    localparam logic [15:0] NMI_VECTOR = 16'h0066;

    function automatic logic [2:0] first_set(input logic [7:0] v);
        first_set = '0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) first_set = 3'(i);
    endfunction

endpackage

// File: rtl/magic_nmi_hub_bus.sv
// CPU bus bundle seen by the hub: address, data and Z80 strobes.
interface cpu_bus;
    logic [15:0] a;
    logic [7:0]  d;
    logic        mreq;
    logic        ioreq;
    logic        rd;
    logic        wr;
    logic        m1;
    logic        mreq_rise;

    modport hub (input a, d, mreq, ioreq, rd, wr, m1, mreq_rise);
    modport cpu (output a, d, mreq, ioreq, rd, wr, m1, mreq_rise);
endinterface

// File: rtl/magic_nmi_hub_cfg_bank.sv
// Config register bank behind the magic I/O port.
// Register 0 is the live status byte, the rest are writable.
module magic_cfg_bank
    import magic_nmi_hub_pkg::*;
#(
    parameter int                    CFG_REGS  = 16,
    parameter logic [CFG_REGS*8-1:0] CFG_RESET = '0
) (
    input  logic                  clk28,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [7:0]            idx,
    input  logic [7:0]            d,
    input  logic [7:0]            status,
    output logic [CFG_REGS*8-1:0] cfg_q,
    output logic [7:0]            d_out,
    output logic                  d_out_active
);

    localparam int IW = (CFG_REGS > 2) ? $clog2(CFG_REGS) : 1;
    localparam logic [8:0] NREG = 9'(CFG_REGS);

    logic [7:0]    regs [1:CFG_REGS-1];
    logic [IW-1:0] sel;
    logic          in_range;
    logic          is_status;
    logic [7:0]    rd_val;

    assign sel       = idx[IW-1:0];
    assign in_range  = {1'b0, idx} < NREG;
    assign is_status = idx == 8'(CFG_IDX_STATUS);

    assign cfg_q[7:0] = status;
    for (genvar i = 1; i < CFG_REGS; i++) begin : g_q
        assign cfg_q[i*8 +: 8] = regs[i];
    end

    always_comb begin
        rd_val = 8'hFF;
        if (is_status)     rd_val = status;
        else if (in_range) rd_val = regs[sel];
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            for (int i = 1; i < CFG_REGS; i++)
                regs[i] <= CFG_RESET[i*8 +: 8];
            d_out        <= '0;
            d_out_active <= 1'b0;
        end else begin
            if (cs && wr && in_range && !is_status)
                regs[sel] <= d;
            d_out_active <= cs && rd;
            if (cs && rd)
                d_out <= rd_val;
        end
    end

endmodule

// File: rtl/magic_nmi_hub.sv
// Magic/NMI controller: trigger arbitration, NMI entry with timeout,
// opcode signature check, magic ROM mapping and exit/call handling.
module magic_nmi_hub
    import magic_nmi_hub_pkg::*;
#(
    parameter int                    N_SRC          = 4,
    parameter int                    SIG_LEN        = 2,
    parameter logic [7:0]            SIG_BYTE       = 8'hEB,
    parameter int                    CFG_REGS       = 16,
    parameter logic [7:0]            CFG_PORT       = 8'hFF,
    parameter logic [CFG_REGS*8-1:0] CFG_RESET      = '0,
    parameter int                    NMI_TIMEOUT    = 4095,
    parameter logic [15:0]           EXIT_ADDR      = 16'hF000,
    parameter logic [15:0]           CALL_ADDR      = 16'hF008,
    parameter bit                    MAGIC_ON_START = 1'b1
) (
    input  logic                  clk28,
    input  logic                  rst,
    input  logic                  ck35,
    cpu_bus.hub                   bus,
    input  logic                  n_int,
    input  logic                  n_int_next,
    input  logic [N_SRC-1:0]      trig,
    output logic                  n_nmi,
    output logic                  magic_mode,
    output logic                  magic_map,
    output logic [2:0]            trig_id,
    output logic [CFG_REGS*8-1:0] cfg_q,
    output logic [7:0]            d_out,
    output logic                  d_out_active
);

    localparam int SW = (SIG_LEN > 0) ? $clog2(SIG_LEN + 1) : 1;
    localparam int TW = (NMI_TIMEOUT > 0) ? $clog2(NMI_TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] SIG_INIT = SW'(SIG_LEN);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((NMI_TIMEOUT > 0) ? NMI_TIMEOUT - 1 : 0);
    localparam magic_state_t ST_RST =
        (MAGIC_ON_START && SIG_LEN > 0) ? ST_CHECK : ST_IDLE;

    magic_state_t  state;
    logic [SW-1:0] sig_cnt;
    logic          sig_arm;
    logic          sig_ok;
    logic [TW-1:0] timer;
    logic          tmo;
    logic          nosig;
    logic          int_fall;
    logic          nmi_fetch;
    logic          sig_cap;
    logic          cs;
    logic [7:0]    status;

    assign int_fall  = n_int && !n_int_next;
    assign nmi_fetch = bus.m1 && bus.mreq_rise && bus.a == NMI_VECTOR;
    // A fetch is only checked if its own mreq_rise was seen in CHECK,
    // so the tail of the #0066 fetch never counts as a signature opcode.
    assign sig_cap   = (sig_arm || bus.mreq_rise) && bus.m1
                       && bus.mreq && bus.rd;
    assign cs        = magic_map && bus.ioreq && bus.a[7:0] == CFG_PORT;

    always_comb begin
        status                  = '0;
        status[STATUS_MAP]      = magic_map;
        status[STATUS_MODE]     = magic_mode;
        status[STATUS_ONE]      = 1'b1;
        status[STATUS_NOSIG]    = nosig;
        status[STATUS_TMO]      = tmo;
        status[STATUS_ID +: 3]  = trig_id;
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            state      <= ST_RST;
            sig_cnt    <= SIG_INIT;
            sig_arm    <= 1'b0;
            sig_ok     <= 1'b0;
            timer      <= '0;
            tmo        <= 1'b0;
            nosig      <= 1'b0;
            n_nmi      <= 1'b1;
            magic_mode <= MAGIC_ON_START;
            magic_map  <= MAGIC_ON_START;
            trig_id    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (int_fall && |trig && !magic_mode) begin
                        trig_id    <= first_set(8'(trig));
                        n_nmi      <= 1'b0;
                        magic_mode <= 1'b1;
                        timer      <= '0;
                        tmo        <= 1'b0;
                        nosig      <= 1'b0;
                        state      <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (nmi_fetch) begin
                        n_nmi     <= 1'b1;
                        magic_map <= 1'b1;
                        sig_cnt   <= SIG_INIT;
                        sig_arm   <= 1'b0;
                        state     <= (SIG_LEN == 0) ? ST_MAPPED : ST_CHECK;
                    end else if (ck35 && NMI_TIMEOUT != 0) begin
                        if (timer == TMO_LAST) begin
                            n_nmi      <= 1'b1;
                            magic_mode <= 1'b0;
                            tmo        <= 1'b1;
                            state      <= ST_IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (sig_arm && !bus.rd) begin
                        sig_arm <= 1'b0;
                        if (!sig_ok) begin
                            magic_mode <= 1'b0;
                            magic_map  <= 1'b0;
                            nosig      <= 1'b1;
                            state      <= ST_IDLE;
                        end else if (sig_cnt <= SW'(1)) begin
                            sig_cnt <= '0;
                            state   <= ST_MAPPED;
                        end else begin
                            sig_cnt <= sig_cnt - 1'b1;
                        end
                    end else if (sig_cap) begin
                        sig_arm <= 1'b1;
                        sig_ok  <= bus.d == SIG_BYTE;
                    end
                end
                ST_MAPPED: begin
                    if (bus.mreq && bus.rd && bus.a == EXIT_ADDR) begin
                        magic_mode <= 1'b0;
                        state      <= ST_UNMAP;
                    end else if (bus.mreq && bus.rd && bus.a == CALL_ADDR) begin
                        state <= ST_CALL;
                    end
                end
                ST_UNMAP: begin
                    if (!bus.mreq) begin
                        magic_map <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_CALL: begin
                    if (magic_map) begin
                        if (!bus.mreq) magic_map <= 1'b0;
                    end else if (bus.m1 && bus.mreq_rise) begin
                        magic_map <= 1'b1;
                        state     <= ST_MAPPED;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    magic_cfg_bank #(
        .CFG_REGS  (CFG_REGS),
        .CFG_RESET (CFG_RESET)
    ) u_cfg (
        .clk28        (clk28),
        .rst          (rst),
        .cs           (cs),
        .wr           (bus.wr),
        .rd           (bus.rd),
        .idx          (bus.a[15:8]),
        .d            (bus.d),
        .status       (status),
        .cfg_q        (cfg_q),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

endmodule

// File: tb/tb_magic_nmi_hub.sv
// Randomised bench for magic_nmi_hub against a session-level model.
module tb_magic_nmi_hub;

    localparam int TMO = 8;
    localparam logic [127:0] RST_IMG =
        128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;

    logic         clk28 = 1'b0;
    logic         rst = 1'b1;
    logic         ck35;
    logic         n_int = 1'b1;
    logic         n_int_next = 1'b1;
    logic [3:0]   trig = '0;
    logic         n_nmi;
    logic         magic_mode;
    logic         magic_map;
    logic [2:0]   trig_id;
    logic [127:0] cfg_q;
    logic [7:0]   d_out;
    logic         d_out_active;

    cpu_bus bus ();

    magic_nmi_hub #(
        .N_SRC       (4),
        .NMI_TIMEOUT (TMO),
        .CFG_RESET   (RST_IMG)
    ) dut (
        .clk28        (clk28),
        .rst          (rst),
        .ck35         (ck35),
        .bus          (bus),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .trig         (trig),
        .n_nmi        (n_nmi),
        .magic_mode   (magic_mode),
        .magic_map    (magic_map),
        .trig_id      (trig_id),
        .cfg_q        (cfg_q),
        .d_out        (d_out),
        .d_out_active (d_out_active)
    );

    always #5 clk28 = ~clk28;

    int div = 0;
    int ticks = 0;
    assign ck35 = (div == 7);
    always @(posedge clk28) begin
        div <= (div == 7) ? 0 : div + 1;
        if (ck35) ticks <= ticks + 1;
    end

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] m_cfg [16];
    logic       m_mode, m_map, m_tmo, m_nosig, m_nmi;
    logic [2:0] m_id;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {m_id, m_tmo, m_nosig, 1'b1, m_mode, m_map};
    endfunction

    function automatic logic [127:0] m_image();
        logic [127:0] v;
        v[7:0] = m_status();
        for (int i = 1; i < 16; i++) v[i*8 +: 8] = m_cfg[i];
        return v;
    endfunction

    function automatic logic [7:0] m_read(input int idx);
        if (idx == 0) return m_status();
        if (idx < 16) return m_cfg[idx];
        return 8'hFF;
    endfunction

    function automatic logic [2:0] lowest(input logic [3:0] t);
        for (int i = 0; i < 4; i++)
            if (t[i]) return 3'(i);
        return 3'd0;
    endfunction

    task automatic model_reset();
        logic [127:0] img;
        img = RST_IMG;
        m_mode = 1'b1; m_map = 1'b1; m_nmi = 1'b1;
        m_tmo = 1'b0; m_nosig = 1'b0; m_id = '0;
        for (int i = 0; i < 16; i++) m_cfg[i] = img[i*8 +: 8];
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nmi"},  128'(n_nmi),      128'(m_nmi));
        chk({tag, ".mode"}, 128'(magic_mode), 128'(m_mode));
        chk({tag, ".map"},  128'(magic_map),  128'(m_map));
        chk({tag, ".id"},   128'(trig_id),    128'(m_id));
        chk({tag, ".cfgq"}, cfg_q,            m_image());
    endtask

    task automatic cyc();
        @(posedge clk28);
        #1;
    endtask

    task automatic bus_idle();
        bus.a = '0; bus.d = '0; bus.mreq = 0; bus.ioreq = 0;
        bus.rd = 0; bus.wr = 0; bus.m1 = 0; bus.mreq_rise = 0;
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [7:0] data);
        bus.a = addr; bus.d = data; bus.m1 = 1; bus.mreq = 1;
        bus.rd = 1; bus.mreq_rise = 1;
        cyc();
        bus.mreq_rise = 0;
        cyc();
        bus.m1 = 0; bus.mreq = 0; bus.rd = 0;
        cyc();
        cyc();
    endtask

    task automatic mem_rd(input logic [15:0] addr, output logic mode_mid,
                          output logic map_mid);
        bus.a = addr; bus.mreq = 1; bus.rd = 1;
        cyc();
        mode_mid = magic_mode;
        map_mid = magic_map;
        cyc();
        bus.mreq = 0; bus.rd = 0;
        cyc();
        cyc();
    endtask

    task automatic io_wr(input int idx, input logic [7:0] val);
        bus.a = {8'(idx), 8'hFF}; bus.d = val; bus.ioreq = 1; bus.wr = 1;
        cyc(); cyc(); cyc();
        bus.ioreq = 0; bus.wr = 0;
        cyc();
    endtask

    task automatic cfg_write_chk(input int idx, input logic [7:0] val);
        io_wr(idx, val);
        if (m_map && idx >= 1 && idx < 16) m_cfg[idx] = val;
        chk($sformatf("wr%0d.cfgq", idx), cfg_q, m_image());
    endtask

    task automatic cfg_read_chk(input int idx);
        logic act1, act0;
        logic [7:0] dat;
        bus.a = {8'(idx), 8'hFF}; bus.ioreq = 1; bus.rd = 1;
        cyc();
        act1 = d_out_active;
        dat = d_out;
        cyc();
        bus.ioreq = 0; bus.rd = 0;
        cyc();
        act0 = d_out_active;
        chk($sformatf("rd%0d.act", idx), 128'(act1), 128'(m_map));
        if (m_map)
            chk($sformatf("rd%0d.data", idx), 128'(dat), 128'(m_read(idx)));
        chk($sformatf("rd%0d.release", idx), 128'(act0), 128'(0));
    endtask

    task automatic int_edge(input logic [3:0] t, output int t0);
        trig = t; n_int = 1; n_int_next = 0;
        cyc();
        t0 = ticks;
        n_int = 0;
        cyc();
        n_int = 1; n_int_next = 1; trig = '0;
        cyc();
    endtask

    task automatic enter(input logic [3:0] t, output int t0);
        int_edge(t, t0);
        if (t != 0) begin
            m_id = lowest(t); m_mode = 1; m_nmi = 0;
            m_tmo = 0; m_nosig = 0;
        end
        check_all("enter");
    endtask

    task automatic run_session(input bit force_ok);
        int t0, k, dummy;
        logic [3:0] t;
        logic [7:0] b;
        logic mm, mp;
        bit ok;
        if ($urandom_range(0, 3) == 0) enter(4'b0000, dummy);
        t = 4'($urandom_range(1, 15));
        enter(t, t0);
        if (!force_ok && $urandom_range(0, 2) == 0) begin
            k = 0;
            while (n_nmi === 1'b0 && k < 300) begin
                cyc();
                k++;
            end
            chk("tmo.ticks", 128'(ticks - t0), 128'(TMO));
            m_nmi = 1; m_mode = 0; m_tmo = 1;
            check_all("tmo");
            cfg_read_chk(0);
            return;
        end
        if ($urandom_range(0, 1) == 1) begin
            int_edge(4'($urandom_range(1, 15)), dummy);
            check_all("ignored_int");
        end
        fetch(16'h0066, 8'($urandom));
        m_nmi = 1; m_map = 1;
        check_all("nmi_fetch");
        ok = 1;
        for (int i = 0; i < 2 && ok; i++) begin
            b = 8'hEB;
            if (!force_ok && $urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                if (b == 8'hEB) b = 8'h00;
            end
            fetch(16'h0100 + 16'(i), b);
            if (b != 8'hEB) begin
                m_mode = 0; m_map = 0; m_nosig = 1;
                ok = 0;
            end
            check_all("sig");
        end
        if (!ok) return;
        cfg_read_chk(0);
        cfg_write_chk($urandom_range(0, 20), 8'($urandom));
        cfg_read_chk($urandom_range(0, 20));
        if ($urandom_range(0, 1) == 1) begin
            mem_rd(16'hF008, mm, mp);
            chk("call.mid_map", 128'(mp), 128'(1));
            chk("call.mid_mode", 128'(mm), 128'(1));
            m_map = 0;
            check_all("call_drop");
            cfg_write_chk($urandom_range(1, 15), 8'($urandom));
            fetch(16'($urandom_range(0, 16'h7FFF)), 8'($urandom));
            m_map = 1;
            check_all("call_back");
        end
        mem_rd(16'hF000, mm, mp);
        chk("exit.mid_mode", 128'(mm), 128'(0));
        chk("exit.mid_map", 128'(mp), 128'(1));
        m_mode = 0; m_map = 0;
        check_all("exit");
    endtask

    initial begin
        logic mm, mp;
        int dummy;
        bus_idle();
        rst = 1;
        cyc(); cyc();
        rst = 0;
        model_reset();
        check_all("reset");
        chk("reset.dact", 128'(d_out_active), 128'(0));
        cfg_read_chk(0);
        cfg_read_chk(3);
        fetch(16'h0000, 8'hEB);
        check_all("boot_sig1");
        fetch(16'h0001, 8'hEB);
        check_all("boot_sig2");
        cfg_read_chk(0);
        cfg_write_chk(5, 8'hA5);
        cfg_write_chk(0, 8'h5A);
        cfg_write_chk(20, 8'h3C);
        for (int i = 0; i < 8; i++)
            cfg_write_chk($urandom_range(0, 20), 8'($urandom));
        for (int i = 0; i < 6; i++)
            cfg_read_chk($urandom_range(0, 20));
        mem_rd(16'hF000, mm, mp);
        chk("boot_exit.mid_mode", 128'(mm), 128'(0));
        chk("boot_exit.mid_map", 128'(mp), 128'(1));
        m_mode = 0; m_map = 0;
        check_all("boot_exit");
        cfg_write_chk(5, 8'h11);
        cfg_read_chk(5);
        for (int s = 0; s < 14; s++) run_session(1'b0);
        enter(4'b1000, dummy);
        fetch(16'h0066, 8'h00);
        m_nmi = 1; m_map = 1;
        check_all("pre_rst");
        rst = 1;
        cyc();
        rst = 0;
        model_reset();
        check_all("mid_rst");
        fetch(16'h0000, 8'h00);
        m_mode = 0; m_map = 0; m_nosig = 1;
        check_all("boot_nosig");
        run_session(1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
